// File: rtl/stopwatch_ctrl.sv
// Run-control sequencer for the stopwatch counter chain: button conditioning, run FSM, tick prescaler.
// Optional DEBOUNCE_EN inserts a DB_CYCLES-sample debouncer between synchronizer and edge detector.
module stopwatch_ctrl #(
    parameter int unsigned DIV       = 250000,
    parameter int unsigned PW        = 18,
    parameter int unsigned DB_CYCLES = 65536,
    parameter int unsigned DBW       = 17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic       tick_en,
    output logic       cnt_clr,
    output logic       disp_hold,
    output logic [1:0] state
);

    localparam int unsigned NBTN = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    // Elaboration-time guard against a prescaler or debounce counter too narrow for its terminal count
    if (DIV < 2 || (64'(1) << PW) < 64'(DIV) || (64'(1) << DBW) <= 64'(DB_CYCLES)) begin : g_param_check
        $error("stopwatch_ctrl: illegal DIV/PW/DB_CYCLES/DBW combination");
    end

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] level;
    logic [NBTN-1:0] level_d;
    logic [NBTN-1:0] cmd;

    assign btn_raw = {btn_clr, btn_lap, btn_start};

    // Two-flop synchronizers for the asynchronous push-buttons
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    logic [DBW-1:0]  db_cnt [NBTN];
    logic [NBTN-1:0] db_level;

    // Filtered level flips only after DB_CYCLES consecutive samples disagreeing with it
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            db_level <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    // Registered rising-edge detect: one cmd pulse per press regardless of hold time
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_d <= '0;
            cmd     <= '0;
        end else begin
            level_d <= level;
            cmd     <= level & ~level_d;
        end
    end

    logic cmd_start;
    logic cmd_lap;
    logic cmd_clr;

    assign cmd_start = cmd[0];
    assign cmd_lap   = cmd[1];
    assign cmd_clr   = cmd[2];

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick_d;
    logic          clr_d;
    logic          run_now;
    logic          run_next;

    assign run_now  = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign run_next = (state_d == ST_RUN) || (state_d == ST_LAP);

    // Next-state, prescaler and pulse decode; start outranks clr, clr outranks lap
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_d = ST_RUN;
                end else if (cmd_clr) begin
                    clr_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (cmd_start) begin
                    state_d = ST_PAUSE;
                end else if (cmd_lap) begin
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (cmd_start) begin
                    state_d = ST_PAUSE;
                end else if (cmd_lap) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (cmd_start) begin
                    state_d = ST_RUN;
                end else if (cmd_clr) begin
                    clr_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counting needs both current and next state running, so no tick leaks into PAUSE/IDLE
        if (state_q == ST_IDLE && state_d == ST_RUN) begin
            presc_d = '0;
        end else if (run_now && run_next) begin
            presc_d = (presc_q == PW'(DIV - 1)) ? '0 : presc_q + PW'(1);
            tick_d  = (presc_d == PW'(DIV - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            tick_en <= 1'b0;
            cnt_clr <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_en <= tick_d;
            cnt_clr <= clr_d;
        end
    end

    assign state     = 2'(state_q);
    assign disp_hold = (state_q == ST_LAP);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a cycle reference model queues expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_stopwatch_ctrl;

    localparam int unsigned DIV = 4;
    localparam int unsigned PW  = 2;
    localparam int unsigned DBC = 3;
    localparam int unsigned DBW = 2;
    localparam int          HIST = 12;
`ifdef DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;
    logic       tick_en;
    logic       cnt_clr;
    logic       disp_hold;
    logic [1:0] state;

    stopwatch_ctrl #(
        .DIV      (DIV),
        .PW       (PW),
        .DB_CYCLES(DBC),
        .DBW      (DBW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_start(btn_start),
        .btn_lap  (btn_lap),
        .btn_clr  (btn_clr),
        .tick_en  (tick_en),
        .cnt_clr  (cnt_clr),
        .disp_hold(disp_hold),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       tick;
        logic       clr;
        logic       hold;
    } obs_t;

    obs_t       exp_q[$];
    logic [2:0] ph[$];   // pin samples, newest first
    logic [2:0] fh[$];   // conditioned button levels, newest first
    int         m_st;
    int         m_pre;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         mon_on = 1'b0;

    logic [2:0] m_pin;
    logic [2:0] m_fl;
    logic [2:0] m_cmd;
    obs_t       m_exp;
    int         m_ns;
    bit         m_tick;
    bit         m_clrp;

    function automatic bit running(input int s);
        return (s == 1) || (s == 3);
    endfunction

    // Reference model: button pipeline as history arithmetic, run control as spec rules
    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            foreach (ph[k]) ph[k] = 3'b000;
            foreach (fh[k]) fh[k] = 3'b000;
            ph.push_front(3'b000);
            fh.push_front(3'b000);
            m_st  = 0;
            m_pre = 0;
            m_exp = '0;
        end else begin
            m_pin = {btn_clr, btn_lap, btn_start};
            ph.push_front(m_pin);
            if (DB_ON) begin
                m_fl = fh[0];
                for (int b = 0; b < 3; b++) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int k = 2; k <= int'(DBC) + 1; k++) begin
                        if (ph[k][b] == m_fl[b]) all_diff = 1'b0;
                    end
                    if (all_diff) m_fl[b] = ~m_fl[b];
                end
            end else begin
                m_fl = ph[1];
            end
            fh.push_front(m_fl);
            m_cmd = fh[2] & ~fh[3];

            m_ns   = m_st;
            m_clrp = 1'b0;
            m_tick = 1'b0;
            case (m_st)
                0: if (m_cmd[0]) m_ns = 1; else if (m_cmd[2]) m_clrp = 1'b1;
                1: if (m_cmd[0]) m_ns = 2; else if (m_cmd[1]) m_ns = 3;
                3: if (m_cmd[0]) m_ns = 2; else if (m_cmd[1]) m_ns = 1;
                default: if (m_cmd[0]) m_ns = 1;
                         else if (m_cmd[2]) begin m_clrp = 1'b1; m_ns = 0; end
            endcase
            if (m_st == 0 && m_ns == 1) begin
                m_pre = 0;
            end else if (running(m_st) && running(m_ns)) begin
                m_pre  = (m_pre + 1) % int'(DIV);
                m_tick = (m_pre == int'(DIV) - 1);
            end
            m_st  = m_ns;
            m_exp = {2'(m_ns), m_tick, m_clrp, (m_ns == 3)};
        end
        while (ph.size() > HIST) void'(ph.pop_back());
        while (fh.size() > HIST) void'(fh.pop_back());
        exp_q.push_back(m_exp);
        mon_on = 1'b1;
    end

    // Monitor: one observation per cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_on) begin
            obs_t act;
            obs_t want;
            act = {state, tick_en, cnt_clr, disp_hold};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty cyc=%0d got st=%b tick=%b clr=%b hold=%b with nothing expected",
                         cyc, act.st, act.tick, act.clr, act.hold);
            end else begin
                want = exp_q.pop_front();
                if (act !== want) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got st=%b tick=%b clr=%b hold=%b want st=%b tick=%b clr=%b hold=%b",
                             cyc, act.st, act.tick, act.clr, act.hold,
                             want.st, want.tick, want.clr, want.hold);
                end
            end
        end
    end

    task automatic press(input logic [2:0] m, input int hold, input int gap);
        {btn_clr, btn_lap, btn_start} = m;
        repeat (hold) @(negedge clk);
        {btn_clr, btn_lap, btn_start} = 3'b000;
        repeat (gap) @(negedge clk);
    endtask

    logic [2:0] masks [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b101, 3'b011, 3'b110, 3'b111};

    initial begin
        for (int k = 0; k < HIST; k++) begin
            ph.push_back(3'b000);
            fh.push_back(3'b000);
        end
        // Reset held while the buttons toggle
        repeat (8) begin
            @(negedge clk);
            {btn_clr, btn_lap, btn_start} = 3'($urandom);
        end
        @(negedge clk);
        {btn_clr, btn_lap, btn_start} = 3'b000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);

        // Directed walk through every transition
        press(3'b001, 5, 14);   // IDLE -> RUN
        press(3'b001, 2, 24);   // RUN -> PAUSE, hold 20+ cycles
        press(3'b001, 2, 12);   // PAUSE -> RUN, resume prescaler
        press(3'b010, 3, 14);   // RUN -> LAP
        press(3'b010, 2, 12);   // LAP -> RUN
        press(3'b100, 2, 10);   // clr in RUN ignored
        press(3'b010, 2, 10);   // RUN -> LAP
        press(3'b001, 2, 12);   // LAP -> PAUSE
        press(3'b101, 2, 12);   // start+clr in PAUSE -> RUN
        press(3'b001, 2, 10);   // RUN -> PAUSE
        press(3'b100, 3, 12);   // clr in PAUSE -> IDLE with pulse
        press(3'b100, 2, 10);   // clr in IDLE pulses, stays
        press(3'b010, 2, 10);   // lap in IDLE ignored
        press(3'b001, 2, 10);   // IDLE -> RUN
        @(negedge clk);
        reset_n = 1'b0;         // mid-run reset
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Randomized presses, glitches and resets
        repeat (300) begin
            if ($urandom_range(0, 99) < 3) begin
                reset_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset_n = 1'b1;
            end
            press(masks[$urandom_range(0, 8)], int'($urandom_range(1, DB_ON ? 6 : 4)),
                  int'($urandom_range(0, 10)));
        end

        repeat (12) @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
